key_expand_seq: RTL and testbench
=================================

KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, meaning the largest supported key length in 32-bit words (legal values 4 or 8).
REQ-002 SHALL have parameter RK_IDX_W, default 4, meaning the width of the round-key index output.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a request to begin expansion, sampled only in IDLE.
REQ-006 SHALL have port mode  input  2  meaning key size: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
REQ-007 SHALL have port key_in  input  256  meaning the cipher key, with w0 = key_in[255:224]; AES-128 uses [255:128] and AES-192 uses [255:64].
REQ-008 SHALL have port busy  output  1  meaning high from start acceptance until done.
REQ-009 SHALL have port err  output  1  meaning a 1-cycle pulse when start is rejected.
REQ-010 SHALL have port rk_valid  output  1  meaning rk_data holds a round key.
REQ-011 SHALL have port rk_ready  input  1  meaning the consumer accepts the round key.
REQ-012 SHALL have port rk_data  output  128  meaning the round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-013 SHALL have port rk_idx  output  RK_IDX_W  meaning round number r of rk_data.
REQ-014 SHALL have port rk_last  output  1  meaning rk_data is round Nr.
REQ-015 SHALL have port done  output  1  meaning a 1-cycle pulse after the last round key is accepted.

Function
REQ-016 SHALL implement FSM IDLE -> GEN -> DRAIN -> IDLE.
- IDLE -> GEN: start with a legal mode; key and mode are latched on that edge.
- GEN -> DRAIN: after the last word w[4(Nr+1)-1] has been generated.
- DRAIN -> IDLE: on the handshake of the final round key; done pulses on the following cycle.
REQ-017 SHALL use Nk/Nr of 4/10, 6/12 and 8/14, giving 44, 52 or 60 words and 11, 13 or 15 round keys.
REQ-018 SHALL produce one 32-bit word per non-stalled GEN cycle, using an 8-word sliding window and four S-box instances.
- Words i < Nk are copied from the key.
- Otherwise temp = w[i-1].
- If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk], 24'h0}.
- Else if Nk = 8 and i mod Nk = 4: temp = SubWord(temp).
- Then w[i] = w[i-Nk] ^ temp.
REQ-019 SHALL follow the Rcon sequence 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 for indices 1..10.
REQ-020 SHALL pack words into a 4-word accumulator; on the 4th word the accumulator is transferred to the output register, rk_valid is set and rk_idx increments.
REQ-021 SHALL stall word generation when the accumulator is full and the output register is still valid and not yet accepted; the window, counters and rk_data are held stable.
REQ-022 SHALL complete a handshake on a clock edge where rk_valid and rk_ready are both high; a simultaneous transfer plus reload is allowed, so there is no bubble.
REQ-023 SHALL deliver round key 0 with rk_valid high 4 cycles after the start edge, then one key every 4 cycles with rk_ready held high.
REQ-024 SHALL ignore start while busy; mode 11 (or a mode exceeding MAX_NK) at start SHALL pulse err and remain IDLE.
REQ-025 SHALL keep rk_data and rk_idx stable while rk_valid is high and rk_ready is low.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-expansion, clear to IDLE: busy = 0, err = 0, rk_valid = 0, rk_data = 0, rk_idx = 0, rk_last = 0, done = 0, and clear the accumulator and window.
REQ-027 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro KE_AES192_EN defined, support mode 01 (Nk = 6) as in REQ-018.
REQ-029 SHALL, without KE_AES192_EN, treat mode 01 as illegal (err pulse, no expansion) and omit the Nk = 6 logic.

Verification
REQ-030 SHALL cover AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1 -> round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last = 1, done 1 cycle later.
REQ-031 SHALL cover AES-192 (KE_AES192_EN): key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> round 12 = e98ba06f448c773c8ecc720401002202.
REQ-032 SHALL cover AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-033 SHALL cover backpressure: rk_ready randomly low with the AES-128 vector -> identical key sequence, rk_data stable while stalled, exactly 11 handshakes.
REQ-034 SHALL cover errors: mode 11 at start -> err pulse, busy stays 0; start while busy -> ignored; rst_n low at round 5 -> all outputs 0, new start then yields the correct round 0.

Source files
------------

// File: rtl/key_expand_seq.sv
// key_expand_seq: sequential AES key expansion, one word per cycle, streamed as 128-bit round keys.
// Optional AES-192 (Nk = 6) support is compiled in with `define KE_AES192_EN.

module key_expand_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int b = 0; b < 8; b++) begin
         if (y[b]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 via an addition chain, then the AES affine map
   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
   assign x2   = gf_mul(a, a);
   assign x3   = gf_mul(x2, a);
   assign x6   = gf_mul(x3, x3);
   assign x12  = gf_mul(x6, x6);
   assign x15  = gf_mul(x12, x3);
   assign x30  = gf_mul(x15, x15);
   assign x60  = gf_mul(x30, x30);
   assign x120 = gf_mul(x60, x60);
   assign x240 = gf_mul(x120, x120);
   assign x252 = gf_mul(x240, x12);
   assign inv  = gf_mul(x252, x2);

   assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module key_expand_seq #(
   parameter int MAX_NK   = 8,
   parameter int RK_IDX_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [255:0]        key_in,
   output logic                busy,
   output logic                err,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [127:0]        rk_data,
   output logic [RK_IDX_W-1:0] rk_idx,
   output logic                rk_last,
   output logic                done
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GEN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   logic [1:0]   state;
   logic [255:0] key_sh;
   logic [31:0]  win [8];
   logic [31:0]  acc [3];
   logic [1:0]   acc_cnt;
   logic [5:0]   word_idx;
   logic [5:0]   last_word;
   logic [2:0]   nk_m1;
   logic [2:0]   kpos;
   logic [7:0]   rcon;

   logic         mode_ok;
   logic [2:0]   mode_nk_m1;
   logic [5:0]   mode_last;

   // Key-size decode: Nk-1 and index of the final expanded word
   always_comb begin
      mode_ok    = 1'b0;
      mode_nk_m1 = 3'd3;
      mode_last  = 6'd43;
      case (mode)
         2'b00: mode_ok = 1'b1;
`ifdef KE_AES192_EN
         2'b01: begin
            mode_ok    = (MAX_NK >= 6);
            mode_nk_m1 = 3'd5;
            mode_last  = 6'd51;
         end
`endif
         2'b10: begin
            mode_ok    = (MAX_NK >= 8);
            mode_nk_m1 = 3'd7;
            mode_last  = 6'd59;
         end
         default: mode_ok = 1'b0;
      endcase
   end

   logic        key_phase;
   logic        rot_phase;
   logic        sub_phase;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] temp;
   logic [31:0] w_new;

   assign key_phase = (word_idx <= {3'b000, nk_m1});
   assign rot_phase = !key_phase && (kpos == 3'd0);
   assign sub_phase = !key_phase && (nk_m1 == 3'd7) && (kpos == 3'd4);
   assign sub_in    = rot_phase ? {win[0][23:0], win[0][31:24]} : win[0];

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      key_expand_sbox u_sbox (
         .a (sub_in[8*g +: 8]),
         .s (sub_out[8*g +: 8])
      );
   end

   // win[0] is w[i-1]; win[Nk-1] is w[i-Nk]
   always_comb begin
      temp = win[0];
      if (rot_phase)
         temp = sub_out ^ {rcon, 24'h000000};
      else if (sub_phase)
         temp = sub_out;
      w_new = key_phase ? key_sh[255:224] : (win[nk_m1] ^ temp);
   end

   logic acc_full;
   logic stall;
   logic gen_fire;
   logic hs;

   assign acc_full = (acc_cnt == 2'd3);
   assign stall    = acc_full && rk_valid && !rk_ready;
   assign gen_fire = (state == S_GEN) && !stall;
   assign hs       = rk_valid && rk_ready;
   assign busy     = (state != S_IDLE);

   // Control FSM, sliding window, accumulator and schedule counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         key_sh    <= '0;
         acc_cnt   <= 2'd0;
         word_idx  <= 6'd0;
         last_word <= 6'd0;
         nk_m1     <= 3'd0;
         kpos      <= 3'd0;
         rcon      <= 8'h00;
         err       <= 1'b0;
         done      <= 1'b0;
         for (int j = 0; j < 8; j++) win[j] <= '0;
         for (int j = 0; j < 3; j++) acc[j] <= '0;
      end else begin
         err  <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (mode_ok) begin
                     state     <= S_GEN;
                     key_sh    <= key_in;
                     nk_m1     <= mode_nk_m1;
                     last_word <= mode_last;
                     word_idx  <= 6'd0;
                     kpos      <= 3'd0;
                     rcon      <= 8'h01;
                     acc_cnt   <= 2'd0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_GEN: begin
               if (gen_fire) begin
                  key_sh <= {key_sh[223:0], 32'h00000000};
                  win[0] <= w_new;
                  for (int j = 1; j < 8; j++) win[j] <= win[j-1];
                  if (!acc_full) acc[acc_cnt] <= w_new;
                  acc_cnt  <= acc_cnt + 2'd1;
                  word_idx <= word_idx + 6'd1;
                  kpos     <= (kpos == nk_m1) ? 3'd0 : kpos + 3'd1;
                  if (rot_phase) rcon <= xtime(rcon);
                  if (word_idx == last_word) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (hs) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output register: loads on the 4th word of a round, even while handing off the previous key
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk_valid <= 1'b0;
         rk_data  <= '0;
         rk_idx   <= '0;
         rk_last  <= 1'b0;
      end else if (gen_fire && acc_full) begin
         rk_valid <= 1'b1;
         rk_data  <= {acc[0], acc[1], acc[2], w_new};
         rk_idx   <= RK_IDX_W'(word_idx[5:2]);
         rk_last  <= (word_idx == last_word);
      end else if (hs) begin
         rk_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq: table-driven directed bench for key_expand_seq using FIPS-197 key schedules,
// plus hand-written backpressure, busy-start and mid-expansion reset sequences.
`timescale 1ns/1ps

module tb_key_expand_seq;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   mode;
   logic [255:0] key_in;
   logic         busy;
   logic         err;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_idx;
   logic         rk_last;
   logic         done;

   always #5 clk = ~clk;

   key_expand_seq #(.MAX_NK(8), .RK_IDX_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .key_in   (key_in),
      .busy     (busy),
      .err      (err),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_data  (rk_data),
      .rk_idx   (rk_idx),
      .rk_last  (rk_last),
      .done     (done)
   );

   typedef struct {
      string        name;
      logic [1:0]   mode;
      logic [255:0] key;
      logic         exp_err;
      int           exp_count;
      logic [127:0] exp_first;
      logic [127:0] exp_second;
      logic [127:0] exp_final;
   } vec_t;

   localparam int NV = 4;
   vec_t vecs [NV];
   logic [127:0] aes128_rk [11];
   logic [255:0] k128;
   logic [255:0] k256;

   int checks = 0;
   int errors = 0;

   logic [127:0] got_data [16];
   logic         got_last [16];
   int           n_hs;
   int           first_valid;
   int           stall_bad;
   int           idx_bad;
   logic         done_ok;
   logic         timed_out;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Caller is at a falling edge; returns at the falling edge after the start edge
   task automatic applyStimulus(input logic [1:0] m, input logic [255:0] k);
      start  = 1'b1;
      mode   = m;
      key_in = k;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Collect handshaken round keys; cyc counts rising edges since the start edge
   task automatic collectKeys(input bit rnd_ready, input int cyc0);
      int           cyc;
      logic [127:0] held_data;
      logic [3:0]   held_idx;
      logic         held_v;
      bit           finished;
      n_hs        = 0;
      first_valid = -1;
      stall_bad   = 0;
      idx_bad     = 0;
      done_ok     = 1'b0;
      timed_out   = 1'b0;
      held_v      = 1'b0;
      held_data   = '0;
      held_idx    = '0;
      finished    = 1'b0;
      cyc         = cyc0;
      while (!finished) begin
         if (rk_valid && first_valid < 0) first_valid = cyc;
         if (held_v && (!rk_valid || rk_data !== held_data || rk_idx !== held_idx)) stall_bad++;
         rk_ready  = rnd_ready ? ($urandom_range(0, 99) >= 40) : 1'b1;
         held_v    = rk_valid && !rk_ready;
         held_data = rk_data;
         held_idx  = rk_idx;
         if (rk_valid && rk_ready) begin
            if (n_hs < 16) begin
               got_data[n_hs] = rk_data;
               got_last[n_hs] = rk_last;
            end
            if (int'(rk_idx) != n_hs) idx_bad++;
            n_hs++;
            if (rk_last) begin
               @(negedge clk);
               done_ok = done && !busy;
               @(negedge clk);
               done_ok = done_ok && !done;
               finished = 1'b1;
            end
         end
         if (!finished) begin
            @(negedge clk);
            cyc++;
            if (cyc > cyc0 + 600) begin
               timed_out = 1'b1;
               finished  = 1'b1;
            end
         end
      end
      rk_ready = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic reached;
      k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
      k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

      aes128_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      aes128_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      aes128_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      aes128_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      aes128_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      aes128_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      aes128_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      aes128_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      aes128_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      aes128_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      aes128_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      vecs[0] = '{"aes128", 2'b00, k128, 1'b0, 11, aes128_rk[0], aes128_rk[1], aes128_rk[10]};
      vecs[1] = '{"aes256", 2'b10, k256, 1'b0, 15,
                  128'h603deb1015ca71be2b73aef0857d7781,
                  128'h1f352c073b6108d72d9810a30914dff4,
                  128'hfe4890d1e6188d0b046df344706c631e};
`ifdef KE_AES192_EN
      vecs[2] = '{"aes192", 2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                  1'b0, 13,
                  128'h8e73b0f7da0e6452c810f32b809079e5,
                  128'h62f8ead2522c6b7bfe0c91f72402f5a5,
                  128'he98ba06f448c773c8ecc720401002202};
`else
      vecs[2] = '{"mode01_off", 2'b01, k128, 1'b1, 0, '0, '0, '0};
`endif
      vecs[3] = '{"mode11", 2'b11, k128, 1'b1, 0, '0, '0, '0};

      rst_n    = 1'b0;
      start    = 1'b0;
      mode     = 2'b00;
      key_in   = '0;
      rk_ready = 1'b1;
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_rk_valid", rk_valid, 0);
      checkOutput("reset_rk_data", rk_data, 0);
      checkOutput("reset_rk_idx_last_done", {rk_idx, rk_last, done}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < NV; v++) begin
         applyStimulus(vecs[v].mode, vecs[v].key);
         checkOutput({vecs[v].name, "_err"}, err, vecs[v].exp_err);
         checkOutput({vecs[v].name, "_busy"}, busy, !vecs[v].exp_err);
         if (vecs[v].exp_err) begin
            @(negedge clk);
            checkOutput({vecs[v].name, "_err_pulse_end"}, err, 0);
            checkOutput({vecs[v].name, "_busy_idle"}, busy, 0);
         end else begin
            collectKeys(1'b0, 0);
            checkOutput({vecs[v].name, "_timeout"}, timed_out, 0);
            checkOutput({vecs[v].name, "_latency"}, first_valid, 4);
            checkOutput({vecs[v].name, "_count"}, n_hs, vecs[v].exp_count);
            checkOutput({vecs[v].name, "_round0"}, got_data[0], vecs[v].exp_first);
            checkOutput({vecs[v].name, "_round1"}, got_data[1], vecs[v].exp_second);
            checkOutput({vecs[v].name, "_final"}, (n_hs > 0 && n_hs <= 16) ? got_data[n_hs-1] : '0,
                        vecs[v].exp_final);
            checkOutput({vecs[v].name, "_final_last"}, (n_hs > 0 && n_hs <= 16) ? got_last[n_hs-1] : 1'b0, 1);
            checkOutput({vecs[v].name, "_idx_seq"}, idx_bad, 0);
            checkOutput({vecs[v].name, "_done"}, done_ok, 1);
         end
      end

      $display("[TB] backpressure sequence");
      applyStimulus(2'b00, k128);
      collectKeys(1'b1, 0);
      checkOutput("bp_timeout", timed_out, 0);
      checkOutput("bp_count", n_hs, 11);
      checkOutput("bp_stable", stall_bad, 0);
      checkOutput("bp_idx_seq", idx_bad, 0);
      checkOutput("bp_done", done_ok, 1);
      for (int r = 0; r < 11; r++)
         checkOutput($sformatf("bp_round%0d", r), got_data[r], aes128_rk[r]);

      $display("[TB] start while busy sequence");
      applyStimulus(2'b00, k128);
      start  = 1'b1;
      mode   = 2'b10;
      key_in = k256;
      @(negedge clk);
      start  = 1'b0;
      checkOutput("busy_start_err", err, 0);
      collectKeys(1'b0, 1);
      checkOutput("busy_start_count", n_hs, 11);
      checkOutput("busy_start_latency", first_valid, 4);
      checkOutput("busy_start_final", got_data[10], aes128_rk[10]);

      $display("[TB] reset mid-expansion sequence");
      applyStimulus(2'b00, k128);
      reached = 1'b0;
      for (int c = 0; c < 100 && !reached; c++) begin
         if (rk_valid && rk_idx == 4'd5) reached = 1'b1;
         else @(negedge clk);
      end
      checkOutput("rst_mid_reach_round5", reached, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_outputs", {busy, err, rk_valid, rk_last, done, rk_idx, rk_data}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(2'b00, k128);
      checkOutput("rst_restart_busy", busy, 1);
      collectKeys(1'b0, 0);
      checkOutput("rst_restart_latency", first_valid, 4);
      checkOutput("rst_restart_round0", got_data[0], aes128_rk[0]);
      checkOutput("rst_restart_count", n_hs, 11);
      checkOutput("rst_restart_final", got_data[10], aes128_rk[10]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
